// File: rtl/fft16_top.sv
// Iterative 16-point radix-2 DIT FFT with one shared butterfly and one complex multiplier.
// Runs LOAD (1) -> CALC (4 stages x 8 butterflies x 2 cycles) -> DONE (1) continuously.
module fft16_top #(
    parameter int N      = 16,
    parameter int Q      = 8,
    parameter int STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] in0_re,  in1_re,  in2_re,  in3_re,
    input  logic [N-1:0] in4_re,  in5_re,  in6_re,  in7_re,
    input  logic [N-1:0] in8_re,  in9_re,  in10_re, in11_re,
    input  logic [N-1:0] in12_re, in13_re, in14_re, in15_re,
    input  logic [N-1:0] in0_im,  in1_im,  in2_im,  in3_im,
    input  logic [N-1:0] in4_im,  in5_im,  in6_im,  in7_im,
    input  logic [N-1:0] in8_im,  in9_im,  in10_im, in11_im,
    input  logic [N-1:0] in12_im, in13_im, in14_im, in15_im,
    output logic [N-1:0] out0_re,  out1_re,  out2_re,  out3_re,
    output logic [N-1:0] out4_re,  out5_re,  out6_re,  out7_re,
    output logic [N-1:0] out8_re,  out9_re,  out10_re, out11_re,
    output logic [N-1:0] out12_re, out13_re, out14_re, out15_re,
    output logic [N-1:0] out0_im,  out1_im,  out2_im,  out3_im,
    output logic [N-1:0] out4_im,  out5_im,  out6_im,  out7_im,
    output logic [N-1:0] out8_im,  out9_im,  out10_im, out11_im,
    output logic [N-1:0] out12_im, out13_im, out14_im, out15_im,
    output logic         o_FFT_cycle_done,
    output logic [N-1:0] w_out0_re_butterfly, w_out0_im_butterfly,
    output logic [N-1:0] w_out1_re_butterfly, w_out1_im_butterfly,
    output logic [N-1:0] w_Mux0_out0_re_butterfly_in, w_Mux0_out0_im_butterfly_in,
    output logic [N-1:0] w_Mux0_out1_re_butterfly_in, w_Mux0_out1_im_butterfly_in,
    output logic [N-1:0] w_Mux0_out_twiddle_re, w_Mux0_out_twiddle_im,
    output logic [1:0]   o_Mux_switcher_butterfly,
    output logic         o_butterfly_done,
    output logic         w_mutiplier_done
);
    localparam int PW = 2 * N + 1;

    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic signed [N-1:0] r_mem_re [16];
    logic signed [N-1:0] r_mem_im [16];
    logic signed [N-1:0] r_p_re, r_p_im;
    logic [15:0][N-1:0]  r_out_re, r_out_im;
    logic [15:0][N-1:0]  w_in_re, w_in_im;

    logic                w_calc;
    logic [1:0]          w_stage;
    logic [2:0]          w_bfly;
    logic [3:0]          w_top, w_bot;
    logic [2:0]          w_tw_k;
    logic signed [N-1:0] w_rom_re, w_rom_im;
    logic signed [N-1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_tw_re, w_tw_im;
    logic signed [N-1:0] w_p_re, w_p_im;
    logic signed [N-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

    assign w_in_re = {in15_re, in14_re, in13_re, in12_re, in11_re, in10_re, in9_re, in8_re,
                      in7_re,  in6_re,  in5_re,  in4_re,  in3_re,  in2_re,  in1_re, in0_re};
    assign w_in_im = {in15_im, in14_im, in13_im, in12_im, in11_im, in10_im, in9_im, in8_im,
                      in7_im,  in6_im,  in5_im,  in4_im,  in3_im,  in2_im,  in1_im, in0_im};
    assign {out15_re, out14_re, out13_re, out12_re, out11_re, out10_re, out9_re, out8_re,
            out7_re,  out6_re,  out5_re,  out4_re,  out3_re,  out2_re,  out1_re, out0_re} = r_out_re;
    assign {out15_im, out14_im, out13_im, out12_im, out11_im, out10_im, out9_im, out8_im,
            out7_im,  out6_im,  out5_im,  out4_im,  out3_im,  out2_im,  out1_im, out0_im} = r_out_im;

    function automatic logic [3:0] bitrev(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    assign w_calc  = (r_state == CALC);
    assign w_stage = r_cnt[5:4];
    assign w_bfly  = r_cnt[3:1];

    // Top index places bit s of the address at 0 and j below it; twiddle exponent is j << (3-s).
    always_comb begin
        w_top  = 4'd0;
        w_tw_k = 3'd0;
        case (w_stage)
            2'd0:    begin w_top = {w_bfly, 1'b0};                   w_tw_k = 3'd0;                end
            2'd1:    begin w_top = {w_bfly[2:1], 1'b0, w_bfly[0]};   w_tw_k = {w_bfly[0], 2'b00};  end
            2'd2:    begin w_top = {w_bfly[2], 1'b0, w_bfly[1:0]};   w_tw_k = {w_bfly[1:0], 1'b0}; end
            default: begin w_top = {1'b0, w_bfly};                   w_tw_k = w_bfly;              end
        endcase
    end
    assign w_bot = w_top | (4'd1 << w_stage);

    always_comb begin
        w_rom_re = 16'h0100;
        w_rom_im = 16'h0000;
        case (w_tw_k)
            3'd0:    begin w_rom_re = 16'h0100; w_rom_im = 16'h0000; end
            3'd1:    begin w_rom_re = 16'h00ED; w_rom_im = 16'hFF9E; end
            3'd2:    begin w_rom_re = 16'h00B5; w_rom_im = 16'hFF4B; end
            3'd3:    begin w_rom_re = 16'h0062; w_rom_im = 16'hFF13; end
            3'd4:    begin w_rom_re = 16'h0000; w_rom_im = 16'hFF00; end
            3'd5:    begin w_rom_re = 16'hFF9E; w_rom_im = 16'hFF13; end
            3'd6:    begin w_rom_re = 16'hFF4B; w_rom_im = 16'hFF4B; end
            default: begin w_rom_re = 16'hFF13; w_rom_im = 16'hFF9E; end
        endcase
    end

    assign w_a_re  = w_calc ? r_mem_re[w_top] : '0;
    assign w_a_im  = w_calc ? r_mem_im[w_top] : '0;
    assign w_b_re  = w_calc ? r_mem_re[w_bot] : '0;
    assign w_b_im  = w_calc ? r_mem_im[w_bot] : '0;
    assign w_tw_re = w_calc ? w_rom_re : '0;
    assign w_tw_im = w_calc ? w_rom_im : '0;

    assign w_Mux0_out0_re_butterfly_in = w_a_re;
    assign w_Mux0_out0_im_butterfly_in = w_a_im;
    assign w_Mux0_out1_re_butterfly_in = w_b_re;
    assign w_Mux0_out1_im_butterfly_in = w_b_im;
    assign w_Mux0_out_twiddle_re       = w_tw_re;
    assign w_Mux0_out_twiddle_im       = w_tw_im;
    assign o_Mux_switcher_butterfly    = w_calc ? w_stage : 2'd0;

    // Full-precision products, floor-shifted by Q, keeping the low N bits of the result.
    assign w_p_re = N'((PW'(w_b_re) * PW'(w_tw_re) - PW'(w_b_im) * PW'(w_tw_im)) >>> Q);
    assign w_p_im = N'((PW'(w_b_re) * PW'(w_tw_im) + PW'(w_b_im) * PW'(w_tw_re)) >>> Q);

    assign w_sum_re = w_a_re + r_p_re;
    assign w_sum_im = w_a_im + r_p_im;
    assign w_dif_re = w_a_re - r_p_re;
    assign w_dif_im = w_a_im - r_p_im;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_p_re  <= '0;
            r_p_im  <= '0;
            // NOTE: working memory is cleared too, so an aborted run leaves no partial results behind.
            for (int i = 0; i < 16; i++) begin
                r_mem_re[i] <= '0;
                r_mem_im[i] <= '0;
            end
            r_out_re            <= '0;
            r_out_im            <= '0;
            w_out0_re_butterfly <= '0;
            w_out0_im_butterfly <= '0;
            w_out1_re_butterfly <= '0;
            w_out1_im_butterfly <= '0;
            o_FFT_cycle_done    <= 1'b0;
            o_butterfly_done    <= 1'b0;
            w_mutiplier_done    <= 1'b0;
        end else begin
            o_FFT_cycle_done <= 1'b0;
            o_butterfly_done <= 1'b0;
            w_mutiplier_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    for (int n = 0; n < 16; n++) begin
                        r_mem_re[bitrev(4'(n))] <= w_in_re[n];
                        r_mem_im[bitrev(4'(n))] <= w_in_im[n];
                    end
                    r_cnt   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    if (!r_cnt[0]) begin
                        r_p_re           <= w_p_re;
                        r_p_im           <= w_p_im;
                        w_mutiplier_done <= 1'b1;
                    end else begin
                        // NOTE: A is re-read here; memory only changes at this edge, so it is still the cycle-1 operand.
                        r_mem_re[w_top]     <= w_sum_re;
                        r_mem_im[w_top]     <= w_sum_im;
                        r_mem_re[w_bot]     <= w_dif_re;
                        r_mem_im[w_bot]     <= w_dif_im;
                        w_out0_re_butterfly <= w_sum_re;
                        w_out0_im_butterfly <= w_sum_im;
                        w_out1_re_butterfly <= w_dif_re;
                        w_out1_im_butterfly <= w_dif_im;
                        o_butterfly_done    <= 1'b1;
                    end
                    if (r_cnt == 6'(STAGES * 16 - 1)) r_state <= DONE;
                    r_cnt <= r_cnt + 6'd1;
                end
                DONE: begin
                    for (int i = 0; i < 16; i++) begin
                        r_out_re[i] <= r_mem_re[i];
                        r_out_im[i] <= r_mem_im[i];
                    end
                    o_FFT_cycle_done <= 1'b1;
                    r_state          <= LOAD;
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fft16_top.sv
// Directed self-checking bench for fft16_top: reset, timing, known spectra, abort and a DFT model.
module tb_fft16_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_re [16];
    logic [15:0] in_im [16];
    logic [15:0] out_re [16];
    logic [15:0] out_im [16];
    logic        done, bf_done, mul_done;
    logic [1:0]  sw;
    logic [15:0] bo0_re, bo0_im, bo1_re, bo1_im;
    logic [15:0] ma_re, ma_im, mb_re, mb_im, tw_re, tw_im;

    int n_checks = 0;
    int n_fail   = 0;
    int done_edge, bf_count, mul_count;

    logic [15:0] s_ma_re [70];
    logic [15:0] s_mb_re [70];
    logic [15:0] s_tw_re [70];
    logic [15:0] s_tw_im [70];
    logic [15:0] s_bo0_re [70];
    logic [15:0] s_bo1_re [70];
    logic [1:0]  s_sw [70];

    logic [15:0] rom_re [8] = '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062,
                                16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13};
    logic [15:0] rom_im [8] = '{16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13,
                                16'hFF00, 16'hFF13, 16'hFF4B, 16'hFF9E};

    always #5 clk = ~clk;

    fft16_top dut (
        .i_clk(clk), .i_rst(rst),
        .in0_re(in_re[0]),   .in1_re(in_re[1]),   .in2_re(in_re[2]),   .in3_re(in_re[3]),
        .in4_re(in_re[4]),   .in5_re(in_re[5]),   .in6_re(in_re[6]),   .in7_re(in_re[7]),
        .in8_re(in_re[8]),   .in9_re(in_re[9]),   .in10_re(in_re[10]), .in11_re(in_re[11]),
        .in12_re(in_re[12]), .in13_re(in_re[13]), .in14_re(in_re[14]), .in15_re(in_re[15]),
        .in0_im(in_im[0]),   .in1_im(in_im[1]),   .in2_im(in_im[2]),   .in3_im(in_im[3]),
        .in4_im(in_im[4]),   .in5_im(in_im[5]),   .in6_im(in_im[6]),   .in7_im(in_im[7]),
        .in8_im(in_im[8]),   .in9_im(in_im[9]),   .in10_im(in_im[10]), .in11_im(in_im[11]),
        .in12_im(in_im[12]), .in13_im(in_im[13]), .in14_im(in_im[14]), .in15_im(in_im[15]),
        .out0_re(out_re[0]),   .out1_re(out_re[1]),   .out2_re(out_re[2]),   .out3_re(out_re[3]),
        .out4_re(out_re[4]),   .out5_re(out_re[5]),   .out6_re(out_re[6]),   .out7_re(out_re[7]),
        .out8_re(out_re[8]),   .out9_re(out_re[9]),   .out10_re(out_re[10]), .out11_re(out_re[11]),
        .out12_re(out_re[12]), .out13_re(out_re[13]), .out14_re(out_re[14]), .out15_re(out_re[15]),
        .out0_im(out_im[0]),   .out1_im(out_im[1]),   .out2_im(out_im[2]),   .out3_im(out_im[3]),
        .out4_im(out_im[4]),   .out5_im(out_im[5]),   .out6_im(out_im[6]),   .out7_im(out_im[7]),
        .out8_im(out_im[8]),   .out9_im(out_im[9]),   .out10_im(out_im[10]), .out11_im(out_im[11]),
        .out12_im(out_im[12]), .out13_im(out_im[13]), .out14_im(out_im[14]), .out15_im(out_im[15]),
        .o_FFT_cycle_done(done),
        .w_out0_re_butterfly(bo0_re), .w_out0_im_butterfly(bo0_im),
        .w_out1_re_butterfly(bo1_re), .w_out1_im_butterfly(bo1_im),
        .w_Mux0_out0_re_butterfly_in(ma_re), .w_Mux0_out0_im_butterfly_in(ma_im),
        .w_Mux0_out1_re_butterfly_in(mb_re), .w_Mux0_out1_im_butterfly_in(mb_im),
        .w_Mux0_out_twiddle_re(tw_re), .w_Mux0_out_twiddle_im(tw_im),
        .o_Mux_switcher_butterfly(sw),
        .o_butterfly_done(bf_done),
        .w_mutiplier_done(mul_done)
    );

    task automatic set_zero();
        for (int n = 0; n < 16; n++) begin
            in_re[n] = 16'h0000;
            in_im[n] = 16'h0000;
        end
    endtask

    // Edge 1 is the LOAD edge; sample e (1..64) sees CALC cycle e-1; done expected at edge 66.
    task automatic wait_done(input bit scramble);
        done_edge = -1;
        bf_count  = 0;
        mul_count = 0;
        for (int e = 1; e <= 150 && done_edge < 0; e++) begin
            @(posedge clk);
            #1;
            if (e < 70) begin
                s_ma_re[e]  = ma_re;
                s_mb_re[e]  = mb_re;
                s_tw_re[e]  = tw_re;
                s_tw_im[e]  = tw_im;
                s_bo0_re[e] = bo0_re;
                s_bo1_re[e] = bo1_re;
                s_sw[e]     = sw;
            end
            if (bf_done)  bf_count++;
            if (mul_done) mul_count++;
            if (scramble && e == 10) begin
                for (int n = 0; n < 16; n++) begin
                    in_re[n] = 16'h3A5C ^ 16'(n * 37);
                    in_im[n] = 16'h1234 + 16'(n);
                end
            end
            if (done) done_edge = e;
        end
    endtask

    task automatic test_reset();
        set_zero();
        in_re[0] = 16'h0100;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_re[k] !== 16'h0 || out_im[k] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_out%0d: got %h/%h, want 0000/0000", k, out_re[k], out_im[k]);
            end
        end
        n_checks++;
        if ({done, bf_done, mul_done, sw} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got done=%b bf=%b mul=%b sw=%0d, want all 0", done, bf_done, mul_done, sw);
        end
        n_checks++;
        if ({bo0_re, bo0_im, bo1_re, bo1_im, ma_re, ma_im, mb_re, mb_im, tw_re, tw_im} !== 160'b0) begin
            n_fail++;
            $display("FAIL reset_debug: got bo0=%h bo1=%h a=%h b=%h tw=%h/%h, want 0", bo0_re, bo1_re, ma_re, mb_re, tw_re, tw_im);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_done_impulse();
        wait_done(1'b0);
        n_checks++;
        if (done_edge !== 66) begin
            n_fail++;
            $display("FAIL first_done_latency: got edge %0d, want 66", done_edge);
        end
        n_checks++;
        if (bf_count !== 32 || mul_count !== 32) begin
            n_fail++;
            $display("FAIL pulse_counts: got bf=%0d mul=%0d, want 32/32", bf_count, mul_count);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_re[k] !== 16'h0100 || out_im[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL impulse_out%0d: got %h/%h, want 0100/0000", k, out_re[k], out_im[k]);
            end
        end
    endtask

    task automatic test_dc();
        logic [15:0] exp_re;
        for (int n = 0; n < 16; n++) begin
            in_re[n] = 16'h0100;
            in_im[n] = 16'h0000;
        end
        wait_done(1'b0);
        n_checks++;
        if (done_edge !== 66 || bf_count !== 32) begin
            n_fail++;
            $display("FAIL period: got edge %0d bf=%0d, want 66/32", done_edge, bf_count);
        end
        for (int k = 0; k < 16; k++) begin
            exp_re = (k == 0) ? 16'h1000 : 16'h0000;
            n_checks++;
            if (out_re[k] !== exp_re || out_im[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL dc_out%0d: got %h/%h, want %h/0000", k, out_re[k], out_im[k], exp_re);
            end
        end
    endtask

    task automatic test_mixed();
        logic [15:0] exp_re [4] = '{16'h0F00, 16'h0600, 16'hFD00, 16'h0600};
        logic [15:0] exp_im [4] = '{16'h0000, 16'h0500, 16'h0000, 16'hFB00};
        set_zero();
        in_re[0] = 16'h0100;
        in_re[1] = 16'h0200;
        in_re[3] = 16'h0300;
        in_re[7] = 16'h0400;
        in_re[8] = 16'h0500;
        wait_done(1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_re[4*i] !== exp_re[i] || out_im[4*i] !== exp_im[i]) begin
                n_fail++;
                $display("FAIL mixed_out%0d: got %h/%h, want %h/%h", 4*i, out_re[4*i], out_im[4*i], exp_re[i], exp_im[i]);
            end
        end
        n_checks++;
        if (s_ma_re[1] !== 16'h0100 || s_mb_re[1] !== 16'h0500 || s_tw_re[1] !== 16'h0100 || s_tw_im[1] !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_operands: got A=%h B=%h W=%h/%h, want 0100 0500 0100/0000", s_ma_re[1], s_mb_re[1], s_tw_re[1], s_tw_im[1]);
        end
        n_checks++;
        if (s_bo0_re[3] !== 16'h0600 || s_bo1_re[3] !== 16'hFC00) begin
            n_fail++;
            $display("FAIL first_butterfly: got A'=%h B'=%h, want 0600 FC00", s_bo0_re[3], s_bo1_re[3]);
        end
        for (int b = 0; b < 8; b++) begin
            n_checks++;
            if (s_tw_re[49+2*b] !== rom_re[b] || s_tw_im[49+2*b] !== rom_im[b]) begin
                n_fail++;
                $display("FAIL twiddle_k%0d: got %h/%h, want %h/%h", b, s_tw_re[49+2*b], s_tw_im[49+2*b], rom_re[b], rom_im[b]);
            end
        end
        for (int e = 1; e <= 64; e++) begin
            n_checks++;
            if (s_sw[e] !== 2'((e - 1) / 16)) begin
                n_fail++;
                $display("FAIL stage_index_c%0d: got %0d, want %0d", e - 1, s_sw[e], (e - 1) / 16);
            end
        end
    endtask

    task automatic test_abort();
        int early = 0;
        for (int n = 0; n < 16; n++) begin
            in_re[n] = 16'h0100;
            in_im[n] = 16'h0000;
        end
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (done) early++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", early);
        end
        n_checks++;
        if (out_re[0] !== 16'h0 || out_re[4] !== 16'h0 || out_im[4] !== 16'h0 || out_re[8] !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got out0=%h out4=%h/%h out8=%h, want 0", out_re[0], out_re[4], out_im[4], out_re[8]);
        end
        set_zero();
        in_re[0] = 16'h0200;
        rst = 1'b0;
        wait_done(1'b0);
        n_checks++;
        if (done_edge !== 66) begin
            n_fail++;
            $display("FAIL abort_restart_latency: got edge %0d, want 66", done_edge);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_re[k] !== 16'h0200 || out_im[k] !== 16'h0000) begin
                n_fail++;
                $display("FAIL abort_new_out%0d: got %h/%h, want 0200/0000", k, out_re[k], out_im[k]);
            end
        end
    endtask

    task automatic test_random();
        int  xr [16];
        int  xi [16];
        real er, ei, ang, dr, di;
        for (int n = 0; n < 16; n++) begin
            xr[n] = int'($urandom_range(48)) - 24;
            xi[n] = int'($urandom_range(48)) - 24;
            in_re[n] = 16'(xr[n]);
            in_im[n] = 16'(xi[n]);
        end
        wait_done(1'b0);
        n_checks++;
        if (done_edge !== 66) begin
            n_fail++;
            $display("FAIL random_period: got edge %0d, want 66", done_edge);
        end
        for (int k = 0; k < 16; k++) begin
            er = 0.0;
            ei = 0.0;
            for (int n = 0; n < 16; n++) begin
                ang = 2.0 * 3.14159265358979 * real'(n * k) / 16.0;
                er += real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
                ei += real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
            end
            dr = real'(int'($signed(out_re[k]))) - er;
            di = real'(int'($signed(out_im[k]))) - ei;
            n_checks++;
            if (dr > 4.0 || dr < -4.0 || di > 4.0 || di < -4.0) begin
                n_fail++;
                $display("FAIL random_out%0d: got %h/%h, want %0.2f/%0.2f +-4 LSB", k, out_re[k], out_im[k], er, ei);
            end
        end
    endtask

    initial begin
        set_zero();
        test_reset();
        test_first_done_impulse();
        test_dc();
        test_mixed();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
